ctrl_muestreo: RTL and testbench
================================

Name: ctrl_muestreo

Overview:
- Autonomous sequencer for the light-sensor peripheral register interface (wr/reg_sel/addr/entrada/salida bus).
- Periodically, or on a manual trigger, it writes the control register's send bit and polls until the peripheral clears it.
- It then reads the data register and presents the 8-bit sample with a one-cycle valid strobe.
- Sits between the peripheral and the LED/UART consumers, in place of the manual button-driven test path.

Parameters:
- PERIODO, 1_000_000, clk cycles spent in ESPERA between automatic samples (≥2).
- TIMEOUT, 65535, max POLL_CHK visits with busy=1 before abort (≥1, only with TIMEOUT_EN).
- ANCHO_CNT, 20, width of the period counter (must hold PERIODO-1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- habilitar  in  1  level; 1 = automatic sampling enabled.
- disparo  in  1  single-cycle manual sample request.
- salida_i  in  32  peripheral read data; bit0 of control reg = busy/send.
- wr_o  out  1  peripheral write strobe.
- reg_sel_o  out  1  0 = control register, 1 = data register.
- addr_o  out  1  data-register word select, always 0 here.
- entrada_o  out  32  peripheral write data.
- dato_o  out  8  last captured sample.
- valido_o  out  1  one-cycle pulse when dato_o updates.
- ocupado_o  out  1  high from INICIO through CAPTURA/ERROR inclusive.
- error_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst=0, async): state=IDLE, counters=0, pendiente=0.
  - All outputs 0: wr_o, reg_sel_o, addr_o, entrada_o, dato_o, valido_o, ocupado_o, error_o.
- Bus outputs are Moore, driven from state only.
  - wr_o=1 only in INICIO; entrada_o=32'h1 in INICIO, otherwise 0.
  - reg_sel_o=1 only in LEER_DIR and CAPTURA.
- IDLE:
  - habilitar=1 → ESPERA with cnt=0.
  - disparo=1 → INICIO.
  - Both in the same cycle → INICIO.
- ESPERA:
  - cnt increments each cycle.
  - cnt==PERIODO-1 or disparo=1 → INICIO.
  - habilitar=0 → IDLE, unless disparo is also set, in which case INICIO.
- INICIO: one cycle, writes send=1 to control register (reg_sel_o=0, addr_o=0) → POLL_DIR; poll counter=0.
- POLL_DIR: reg_sel_o=0, address held → POLL_CHK.
  - salida_i is sampled only in POLL_CHK, which tolerates one cycle of peripheral read latency.
- POLL_CHK:
  - salida_i[0]=0 → LEER_DIR.
  - Otherwise poll counter+1 and → POLL_DIR.
  - With TIMEOUT_EN, if poll counter==TIMEOUT-1 while busy → ERROR.
- LEER_DIR: reg_sel_o=1, addr_o=0 → CAPTURA.
- CAPTURA: dato_o<=salida_i[7:0]; valido_o=1 for this cycle only → ESPERA (cnt=0) if habilitar, else IDLE.
- ERROR: one cycle; error_o<=1; dato_o unchanged; no valido_o; same exit as CAPTURA.
- error_o clears only on reset or on the next successful CAPTURA.
- disparo while ocupado_o=1 sets pendiente (one-deep; extra requests are dropped).
  - On exit from CAPTURA/ERROR with pendiente=1: go INICIO directly and clear pendiente.
- habilitar falling mid-transaction does not abort; the transaction completes, then the normal exit rule applies.
- Latency: disparo at cycle N → wr_o at N+1 → earliest valido_o at N+5 (busy cleared on first poll).

Optional Feature:
- Macro TIMEOUT_EN.
- Defined: poll loop is bounded by TIMEOUT; ERROR state is reachable and error_o is functional.
- Undefined: POLL_CHK loops until busy clears; ERROR state and poll counter are not synthesized; error_o is tied to 0.

Test Plan:
- Reset, then disparo pulse with habilitar=0, peripheral busy for 2 polls, data 32'h0000_00A5:
  - wr_o=1 with entrada_o=1 one cycle after disparo.
  - Then valido_o=1 and dato_o=8'hA5.
  - Then IDLE, ocupado_o=0.
- PERIODO=20, habilitar=1, busy cleared immediately, data 8'h3C:
  - INICIO occurs every 20+5 cycles.
  - valido_o pulses repeatedly with dato_o=8'h3C.
- TIMEOUT_EN, TIMEOUT=8, busy stuck at 1:
  - Exactly 8 POLL_CHK visits, then error_o=1 and no valido_o.
  - Release busy, next disparo → valido_o=1 and error_o=0.
- disparo twice during an active transaction:
  - Exactly one extra transaction starts immediately after CAPTURA; the third request is dropped.
- rst asserted during POLL_DIR:
  - All outputs 0 asynchronously, state IDLE.
  - After release with habilitar=1: first INICIO after PERIODO cycles.
- habilitar deasserted in LEER_DIR:
  - Transaction completes with valido_o=1, then IDLE; no further INICIO.

Source files
------------

// File: rtl/ctrl_muestreo.sv
// Autonomous sampler for the light-sensor register bus: it triggers a conversion, polls busy, then reads the 8-bit sample.
// Optional macro TIMEOUT_EN bounds the busy-poll loop and enables the ERROR path and the sticky error_o flag.
module ctrl_muestreo #(
    parameter int PERIODO   = 1_000_000,
    parameter int TIMEOUT   = 65535,
    parameter int ANCHO_CNT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        habilitar,
    input  logic        disparo,
    input  logic [31:0] salida_i,
    output logic        wr_o,
    output logic        reg_sel_o,
    output logic        addr_o,
    output logic [31:0] entrada_o,
    output logic [7:0]  dato_o,
    output logic        valido_o,
    output logic        ocupado_o,
    output logic        error_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ESPERA   = 3'd1;
    localparam logic [2:0] INICIO   = 3'd2;
    localparam logic [2:0] POLL_DIR = 3'd3;
    localparam logic [2:0] POLL_CHK = 3'd4;
    localparam logic [2:0] LEER_DIR = 3'd5;
    localparam logic [2:0] CAPTURA  = 3'd6;
`ifdef TIMEOUT_EN
    localparam logic [2:0] ERROR    = 3'd7;
    localparam int ANCHO_POLL = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

    logic [2:0]           estado_q, estado_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;
    logic                 pendiente_q, pendiente_d;
    logic [7:0]           dato_q, dato_d;
    logic                 ocupado;
    logic                 fin_transaccion;
`ifdef TIMEOUT_EN
    logic [ANCHO_POLL-1:0] poll_q, poll_d;
    logic                  error_q, error_d;
`endif

    // Only the low byte of the data register carries the sample.
    logic unused_salida;
    assign unused_salida = ^salida_i[31:8];

    always_comb begin
        ocupado = 1'b0;
        case (estado_q)
            INICIO, POLL_DIR, POLL_CHK, LEER_DIR, CAPTURA: ocupado = 1'b1;
`ifdef TIMEOUT_EN
            ERROR:                                         ocupado = 1'b1;
`endif
            default:                                       ocupado = 1'b0;
        endcase
    end

    // NOTE: every variable assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        estado_d        = estado_q;
        cnt_d           = cnt_q;
        pendiente_d     = pendiente_q;
        dato_d          = dato_q;
        fin_transaccion = 1'b0;
`ifdef TIMEOUT_EN
        poll_d          = poll_q;
        error_d         = error_q;
`endif

        if (ocupado && disparo) begin
            pendiente_d = 1'b1;
        end

        case (estado_q)
            IDLE: begin
                if (disparo) begin
                    estado_d = INICIO;
                end else if (habilitar) begin
                    estado_d = ESPERA;
                    cnt_d    = '0;
                end
            end

            ESPERA: begin
                cnt_d = cnt_q + ANCHO_CNT'(1);
                if (disparo) begin
                    estado_d = INICIO;
                end else if (!habilitar) begin
                    estado_d = IDLE;
                end else if (cnt_q == ANCHO_CNT'(PERIODO - 1)) begin
                    estado_d = INICIO;
                end
            end

            INICIO: begin
                estado_d = POLL_DIR;
`ifdef TIMEOUT_EN
                poll_d   = '0;
`endif
            end

            POLL_DIR: begin
                estado_d = POLL_CHK;
            end

            // The control-register read issued in POLL_DIR is valid here, one cycle later.
            POLL_CHK: begin
                if (!salida_i[0]) begin
                    estado_d = LEER_DIR;
`ifdef TIMEOUT_EN
                end else if (poll_q == ANCHO_POLL'(TIMEOUT - 1)) begin
                    estado_d = ERROR;
                end else begin
                    poll_d   = poll_q + ANCHO_POLL'(1);
                    estado_d = POLL_DIR;
                end
`else
                end else begin
                    estado_d = POLL_DIR;
                end
`endif
            end

            LEER_DIR: begin
                estado_d = CAPTURA;
            end

            CAPTURA: begin
                dato_d          = salida_i[7:0];
                fin_transaccion = 1'b1;
`ifdef TIMEOUT_EN
                error_d         = 1'b0;
`endif
            end

`ifdef TIMEOUT_EN
            ERROR: begin
                error_d         = 1'b1;
                fin_transaccion = 1'b1;
            end
`endif

            default: begin
                estado_d = IDLE;
            end
        endcase

        // A request arriving in the final cycle itself is honoured like a queued one.
        if (fin_transaccion) begin
            if (pendiente_q || disparo) begin
                estado_d    = INICIO;
                pendiente_d = 1'b0;
            end else if (habilitar) begin
                estado_d = ESPERA;
                cnt_d    = '0;
            end else begin
                estado_d = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q    <= IDLE;
            cnt_q       <= '0;
            pendiente_q <= 1'b0;
            dato_q      <= '0;
        end else begin
            estado_q    <= estado_d;
            cnt_q       <= cnt_d;
            pendiente_q <= pendiente_d;
            dato_q      <= dato_d;
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_q  <= '0;
            error_q <= 1'b0;
        end else begin
            poll_q  <= poll_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    assign wr_o      = (estado_q == INICIO);
    assign entrada_o = {31'd0, estado_q == INICIO};
    assign reg_sel_o = (estado_q == LEER_DIR) || (estado_q == CAPTURA);
    assign addr_o    = 1'b0;
    assign valido_o  = (estado_q == CAPTURA);
    assign ocupado_o = ocupado;
    // The data-register read lands during CAPTURA; show it alongside the strobe, then hold it.
    assign dato_o    = (estado_q == CAPTURA) ? salida_i[7:0] : dato_q;

endmodule

// File: tb/tb_ctrl_muestreo.sv
// Scoreboard bench for ctrl_muestreo: a behavioural peripheral, directed stimulus, and a monitor checking every sample strobe.
module tb_ctrl_muestreo;

    localparam int PERIODO = 20;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        habilitar = 1'b0;
    logic        disparo = 1'b0;
    logic [31:0] salida_i = '0;
    logic        wr_o, reg_sel_o, addr_o, valido_o, ocupado_o, error_o;
    logic [31:0] entrada_o;
    logic [7:0]  dato_o;

    ctrl_muestreo #(.PERIODO(PERIODO), .TIMEOUT(TIMEOUT), .ANCHO_CNT(8)) dut (
        .clk(clk), .rst(rst), .habilitar(habilitar), .disparo(disparo),
        .salida_i(salida_i), .wr_o(wr_o), .reg_sel_o(reg_sel_o), .addr_o(addr_o),
        .entrada_o(entrada_o), .dato_o(dato_o), .valido_o(valido_o),
        .ocupado_o(ocupado_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         inicio_cyc[$];

    // Peripheral model settings
    logic [7:0] dato_periferico = 8'h00;
    int         busy_cfg = 0;
    bit         busy_stuck = 1'b0;
    int         since_wr = 1000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Peripheral: busy reads back 1 for busy_cfg polls after a send write.
    initial begin
        forever begin
            @(negedge clk);
            if (wr_o) since_wr = 0;
            else if (since_wr < 1000) since_wr++;
            if (reg_sel_o) salida_i = {24'd0, dato_periferico};
            else salida_i = {31'd0, busy_stuck || (since_wr <= 2 * busy_cfg)};
        end
    end

    // Monitor: pops one expected sample per strobe and logs each send write.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (wr_o) inicio_cyc.push_back(cyc);
            if (valido_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got dato %0h expected no strobe (cycle %0d)", dato_o, cyc);
                end else begin
                    check("sb_dato", {24'd0, dato_o}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // Pulses disparo for one cycle; returns at the negedge of the INICIO cycle.
    task automatic do_disparo();
        @(negedge clk);
        disparo = 1'b1;
        @(negedge clk);
        disparo = 1'b0;
        #2;
    endtask

    task automatic wait_valid(input string name, input int budget, output int lat);
        bit seen;
        seen = 1'b0;
        lat = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #2;
            lat++;
            if (valido_o) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no valido_o within %0d cycles, expected a strobe", name, budget);
        end
    endtask

    initial begin
        int lat;
        int nb;
        int c0;
        int r;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {wr_o, reg_sel_o, addr_o, entrada_o[28:0], dato_o, valido_o, ocupado_o, error_o},
              32'd0);
        check("reset_entrada", entrada_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Manual sample, busy for two polls
        busy_cfg = 2;
        dato_periferico = 8'hA5;
        exp_q.push_back(8'hA5);
        do_disparo();
        check("t1_wr", {31'd0, wr_o}, 32'd1);
        check("t1_entrada", entrada_o, 32'h1);
        check("t1_ocupado", {31'd0, ocupado_o}, 32'd1);
        wait_valid("t1_wait", 20, lat);
        check("t1_latency", lat, 8);
        check("t1_dato", {24'd0, dato_o}, 32'h0000_00A5);
        @(negedge clk);
        #2;
        check("t1_idle", {29'd0, ocupado_o, valido_o, reg_sel_o}, 32'd0);
        check("t1_dato_hold", {24'd0, dato_o}, 32'h0000_00A5);

        // Minimum latency: busy already clear on the first poll
        busy_cfg = 0;
        dato_periferico = 8'h11;
        exp_q.push_back(8'h11);
        do_disparo();
        wait_valid("t1b_wait", 20, lat);
        check("t1b_latency", lat, 4);

        // Periodic sampling
        repeat (3) @(negedge clk);
        dato_periferico = 8'h3C;
        for (int i = 0; i < 3; i++) exp_q.push_back(8'h3C);
        nb = inicio_cyc.size();
        @(negedge clk);
        habilitar = 1'b1;
        c0 = cyc;
        repeat (80) @(negedge clk);
        habilitar = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        check("t2_count", inicio_cyc.size() - nb, 3);
        if (inicio_cyc.size() - nb == 3) begin
            check("t2_first", inicio_cyc[nb] - c0, 21);
            check("t2_period_a", inicio_cyc[nb + 1] - inicio_cyc[nb], 25);
            check("t2_period_b", inicio_cyc[nb + 2] - inicio_cyc[nb + 1], 25);
        end
        check("t2_drained", exp_q.size(), 0);

        // Busy stuck high
        busy_stuck = 1'b1;
        do_disparo();
`ifdef TIMEOUT_EN
        k = 0;
        for (int i = 0; i < 40 && !error_o; i++) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("t3_timeout_cycles", k, 18);
        check("t3_error", {31'd0, error_o}, 32'd1);
        check("t3_released", {31'd0, ocupado_o}, 32'd0);
        busy_stuck = 1'b0;
        dato_periferico = 8'h5A;
        exp_q.push_back(8'h5A);
        do_disparo();
        check("t3_error_sticky", {31'd0, error_o}, 32'd1);
        wait_valid("t3_wait", 20, lat);
        check("t3_latency", lat, 4);
        @(negedge clk);
        #2;
        check("t3_error_clear", {31'd0, error_o}, 32'd0);
`else
        k = 0;
        repeat (40) @(negedge clk);
        #2;
        check("t3_still_busy", {31'd0, ocupado_o}, 32'd1);
        check("t3_no_error", {31'd0, error_o}, 32'd0);
        busy_stuck = 1'b0;
        dato_periferico = 8'h5A;
        exp_q.push_back(8'h5A);
        wait_valid("t3_wait", 10, lat);
        @(negedge clk);
        #2;
        check("t3_idle", {31'd0, ocupado_o}, 32'd0);
`endif

        // Two extra requests mid-transaction: one runs, one is dropped
        repeat (3) @(negedge clk);
        busy_cfg = 2;
        dato_periferico = 8'h77;
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h77);
        nb = inicio_cyc.size();
        do_disparo();
        @(negedge clk);
        disparo = 1'b1;
        @(negedge clk);
        disparo = 1'b0;
        @(negedge clk);
        disparo = 1'b1;
        @(negedge clk);
        disparo = 1'b0;
        repeat (40) @(negedge clk);
        #2;
        check("t4_count", inicio_cyc.size() - nb, 2);
        if (inicio_cyc.size() - nb == 2) check("t4_back_to_back", inicio_cyc[nb + 1] - inicio_cyc[nb], 9);
        check("t4_drained", exp_q.size(), 0);

        // Asynchronous reset during POLL_DIR
        dato_periferico = 8'hC3;
        do_disparo();
        @(negedge clk);
        #2;
        check("t5_in_poll", {30'd0, ocupado_o, reg_sel_o}, 32'd2);
        rst = 1'b0;
        habilitar = 1'b1;
        #1;
        check("t5_async_outputs", {wr_o, reg_sel_o, addr_o, entrada_o[28:0], dato_o, valido_o, ocupado_o, error_o},
              32'd0);
        check("t5_async_entrada", entrada_o, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r = cyc;
        exp_q.push_back(8'hC3);
        nb = inicio_cyc.size();
        for (int i = 0; i < 40 && inicio_cyc.size() == nb; i++) begin
            @(negedge clk);
            #2;
        end
        check("t5_first_inicio", (inicio_cyc.size() > nb) ? inicio_cyc[nb] - r : -1, 21);

        // habilitar drops during LEER_DIR
        repeat (7) @(negedge clk);
        #2;
        check("t6_leer_dir", {30'd0, reg_sel_o, valido_o}, 32'd2);
        habilitar = 1'b0;
        wait_valid("t6_wait", 5, lat);
        check("t6_latency", lat, 1);
        nb = inicio_cyc.size();
        repeat (60) @(negedge clk);
        #2;
        check("t6_no_more", inicio_cyc.size() - nb, 0);
        check("t6_idle", {31'd0, ocupado_o}, 32'd0);
        check("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
